// File: rtl/lcd_frame_prefetch.sv
// rtl/lcd_frame_prefetch.sv - frame prefetcher feeding the LCD timing driver from SDRAM bursts
// One burst outstanding at a time; FIFO space is reserved before each request.
module lcd_frame_prefetch #(
  parameter int                FIFO_DEPTH = 64,
  parameter int                BURST_LEN  = 16,
  parameter int                H_PIXELS   = 640,
  parameter int                V_LINES    = 480,
  parameter int                ADDR_W     = 22,
  parameter logic [ADDR_W-1:0] FRAME_BASE = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          lcd_request,
  input  logic                          lcd_framesync,
  output logic [15:0]                   lcd_data,
  output logic                          rd_req,
  output logic [ADDR_W-1:0]             rd_addr,
  input  logic                          rd_ack,
  input  logic                          rd_valid,
  input  logic [15:0]                   rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underflow
);

  localparam int          PW         = $clog2(FIFO_DEPTH);
  localparam int          BW         = $clog2(BURST_LEN);
  localparam logic [19:0] TOTAL      = 20'(H_PIXELS * V_LINES);
  localparam logic [BW:0] BEAT_FULL  = (BW+1)'(BURST_LEN);
  localparam logic [PW:0] BURST_ROOM = (PW+1)'(BURST_LEN);

  typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_REQ, S_DATA, S_DRAIN} state_t;

  state_t      r_state;
  logic [PW:0] r_wr_ptr;
  logic [PW:0] r_rd_ptr;
  logic [19:0] r_fetched;
  logic [BW:0] r_beat_cnt;
  logic        r_rd_req;
  logic [15:0] r_lcd_data;
  logic        r_underflow;
  logic [15:0] r_mem [FIFO_DEPTH];

  logic [PW:0] w_level;
  logic [PW:0] w_free;
  logic        w_empty;
  logic        w_wr_en;
  logic [BW:0] w_beat_next;

  assign w_level     = r_wr_ptr - r_rd_ptr;
  assign w_free      = (PW+1)'(FIFO_DEPTH) - w_level;
  assign w_empty     = (w_level == '0);
  // A beat coinciding with framesync belongs to an aborted burst, so it is counted but not stored.
  assign w_wr_en     = (r_state == S_DATA) && rd_valid && !lcd_framesync;
  assign w_beat_next = r_beat_cnt + (BW+1)'(rd_valid);

  assign lcd_data    = r_lcd_data;
  assign rd_req      = r_rd_req;
  assign rd_addr     = FRAME_BASE + ADDR_W'(r_fetched);
  assign fifo_level  = w_level;
  assign underflow   = r_underflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_fetched  <= '0;
      r_beat_cnt <= '0;
      r_rd_req   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (lcd_framesync) r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          r_fetched <= '0;
          r_state   <= S_REQ;
        end
        S_REQ: begin
          if (lcd_framesync) begin
            r_rd_req   <= 1'b0;
            r_beat_cnt <= '0;
            r_state    <= (r_rd_req && rd_ack) ? S_DRAIN : S_FLUSH;
          end else if (r_fetched == TOTAL) begin
            r_rd_req <= 1'b0;
            r_state  <= S_IDLE;
          end else if (r_rd_req && rd_ack) begin
            r_rd_req   <= 1'b0;
            r_beat_cnt <= '0;
            r_state    <= S_DATA;
          end else if (w_free >= BURST_ROOM) begin
            r_rd_req <= 1'b1;
          end
        end
        S_DATA: begin
          if (lcd_framesync) begin
            r_beat_cnt <= w_beat_next;
            r_state    <= S_DRAIN;
          end else if (rd_valid) begin
            r_beat_cnt <= w_beat_next;
            if (w_beat_next == BEAT_FULL) begin
              r_fetched <= r_fetched + 20'(BURST_LEN);
              r_state   <= S_REQ;
            end
          end
        end
        S_DRAIN: begin
          r_beat_cnt <= w_beat_next;
          if (w_beat_next >= BEAT_FULL) r_state <= S_FLUSH;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_lcd_data  <= '0;
      r_underflow <= 1'b0;
    end else if (r_state == S_FLUSH) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_underflow <= 1'b0;
      if (lcd_request) r_lcd_data <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
      if (lcd_request) begin
        if (!w_empty) begin
          r_lcd_data <= r_mem[r_rd_ptr[PW-1:0]];
          r_rd_ptr   <= r_rd_ptr + (PW+1)'(1);
        end else begin
          r_lcd_data  <= '0;
          r_underflow <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[PW-1:0]] <= rd_data;
  end

endmodule

// File: tb/tb_lcd_frame_prefetch.sv
// tb/tb_lcd_frame_prefetch.sv - self-checking bench for lcd_frame_prefetch
// Reduced 64x4 frame at base 0x100000 keeps the full-frame run short.
module tb_lcd_frame_prefetch;

  localparam logic [21:0] BASE = 22'h100000;
  localparam int          NBURST = (64 * 4) / 16;

  logic        clk;
  logic        rst;
  logic        lcd_request;
  logic        lcd_framesync;
  logic [15:0] lcd_data;
  logic        rd_req;
  logic [21:0] rd_addr;
  logic        rd_ack;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic [6:0]  fifo_level;
  logic        underflow;

  lcd_frame_prefetch #(
    .FIFO_DEPTH(64), .BURST_LEN(16), .H_PIXELS(64), .V_LINES(4),
    .ADDR_W(22), .FRAME_BASE(BASE)
  ) dut (
    .clk(clk), .rst(rst), .lcd_request(lcd_request), .lcd_framesync(lcd_framesync),
    .lcd_data(lcd_data), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data(rd_data), .fifo_level(fifo_level), .underflow(underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          checks = 0;
  int          errors = 0;
  bit          resp_en = 1'b0;
  int          burst_cnt;
  int          beat_idx;
  logic [21:0] last_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // SDRAM model: ack two cycles after rd_req, then 16 beats carrying the pixel index.
  initial begin
    rd_ack = 1'b0; rd_valid = 1'b0; rd_data = '0;
    burst_cnt = 0; beat_idx = 0; last_addr = '0;
    forever begin
      @(posedge clk); #2;
      if (resp_en && rd_req) begin
        @(posedge clk); #2;
        rd_ack = 1'b1; last_addr = rd_addr; burst_cnt++; beat_idx = 0;
        @(posedge clk); #2;
        rd_ack = 1'b0;
        for (int i = 0; i < 16; i++) begin
          rd_valid = 1'b1;
          rd_data  = 16'(last_addr - BASE) + 16'(i);
          beat_idx = i + 1;
          @(posedge clk); #2;
        end
        rd_valid = 1'b0;
      end
    end
  end

  typedef struct {
    logic        req;
    logic [15:0] data;
    logic [6:0]  level;
    logic        rdreq;
  } vec_t;

  vec_t        tbl[20];
  logic [21:0] alog[8];
  int          n, prev, base;
  logic [6:0]  lvl;
  bit          seen;

  initial begin
    tbl[0]  = '{1'b1, 16'd0,  7'd63, 1'b0};
    tbl[1]  = '{1'b0, 16'd0,  7'd63, 1'b0};
    tbl[2]  = '{1'b1, 16'd1,  7'd62, 1'b0};
    tbl[3]  = '{1'b1, 16'd2,  7'd61, 1'b0};
    tbl[4]  = '{1'b0, 16'd2,  7'd61, 1'b0};
    tbl[5]  = '{1'b0, 16'd2,  7'd61, 1'b0};
    tbl[6]  = '{1'b1, 16'd3,  7'd60, 1'b0};
    tbl[7]  = '{1'b1, 16'd4,  7'd59, 1'b0};
    tbl[8]  = '{1'b1, 16'd5,  7'd58, 1'b0};
    tbl[9]  = '{1'b1, 16'd6,  7'd57, 1'b0};
    tbl[10] = '{1'b1, 16'd7,  7'd56, 1'b0};
    tbl[11] = '{1'b1, 16'd8,  7'd55, 1'b0};
    tbl[12] = '{1'b1, 16'd9,  7'd54, 1'b0};
    tbl[13] = '{1'b1, 16'd10, 7'd53, 1'b0};
    tbl[14] = '{1'b1, 16'd11, 7'd52, 1'b0};
    tbl[15] = '{1'b1, 16'd12, 7'd51, 1'b0};
    tbl[16] = '{1'b1, 16'd13, 7'd50, 1'b0};
    tbl[17] = '{1'b1, 16'd14, 7'd49, 1'b0};
    tbl[18] = '{1'b1, 16'd15, 7'd48, 1'b0};
    tbl[19] = '{1'b0, 16'd15, 7'd48, 1'b1};

    rst = 1'b1; lcd_request = 1'b0; lcd_framesync = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_lcd_data", 32'(lcd_data), 32'd0);
    chk("rst_rd_req", 32'(rd_req), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'(BASE));
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Pop from an empty FIFO while idle.
    lcd_request = 1'b1;
    @(negedge clk);
    lcd_request = 1'b0;
    chk("empty_pop_data", 32'(lcd_data), 32'd0);
    chk("empty_pop_underflow", 32'(underflow), 32'd1);
    repeat (3) @(negedge clk);
    chk("underflow_sticky", 32'(underflow), 32'd1);

    // Framesync, fill until the FIFO is full.
    resp_en = 1'b1;
    lcd_framesync = 1'b1;
    @(negedge clk);
    lcd_framesync = 1'b0;
    chk("underflow_during_flush", 32'(underflow), 32'd1);
    @(negedge clk);
    chk("underflow_cleared", 32'(underflow), 32'd0);
    n = 0; prev = burst_cnt;
    for (int t = 0; t < 400 && fifo_level != 7'd64; t++) begin
      @(negedge clk);
      if (burst_cnt != prev) begin
        if (n < 8) alog[n] = last_addr;
        n++; prev = burst_cnt;
      end
    end
    resp_en = 1'b0;
    chk("fill_level", 32'(fifo_level), 32'd64);
    chk("fill_bursts", 32'(n), 32'd4);
    for (int k = 0; k < 4 && k < n; k++)
      chk($sformatf("fill_addr%0d", k), 32'(alog[k]), 32'(BASE + 22'(16 * k)));
    repeat (5) @(negedge clk);
    chk("full_no_req", 32'(rd_req), 32'd0);
    chk("full_level_hold", 32'(fifo_level), 32'd64);

    for (int i = 0; i < 20; i++) begin
      lcd_request = tbl[i].req;
      @(negedge clk);
      chk($sformatf("vec%0d_data", i), 32'(lcd_data), 32'(tbl[i].data));
      chk($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(tbl[i].level));
      chk($sformatf("vec%0d_rd_req", i), 32'(rd_req), 32'(tbl[i].rdreq));
    end
    chk("refill_addr", 32'(rd_addr), 32'(BASE + 22'd64));

    lcd_request = 1'b1;
    for (int k = 16; k < 64; k++) begin
      @(negedge clk);
      chk($sformatf("stream_word%0d", k), 32'(lcd_data), 32'(k));
    end
    lcd_request = 1'b0;
    chk("stream_level_empty", 32'(fifo_level), 32'd0);
    chk("stream_no_underflow", 32'(underflow), 32'd0);

    // Framesync with a request pending but not acknowledged.
    lcd_framesync = 1'b1;
    @(negedge clk);
    lcd_framesync = 1'b0;
    chk("fsync_drops_req", 32'(rd_req), 32'd0);
    for (int t = 0; t < 10 && !rd_req; t++) @(negedge clk);
    chk("restart_req", 32'(rd_req), 32'd1);
    chk("restart_req_addr", 32'(rd_addr), 32'(BASE));

    // Framesync in the middle of the burst at 0x40.
    base = burst_cnt; resp_en = 1'b1; lcd_request = 1'b1;
    for (int t = 0; t < 300 && !(burst_cnt - base == 5 && beat_idx == 5); t++) @(negedge clk);
    chk("mid_burst_index", 32'(burst_cnt - base), 32'd5);
    chk("mid_burst_addr", 32'(last_addr), 32'(BASE + 22'h40));
    lcd_request = 1'b0; lcd_framesync = 1'b1;
    @(negedge clk);
    lcd_framesync = 1'b0;
    lvl = fifo_level;
    repeat (4) @(negedge clk);
    chk("drain_level_hold", 32'(fifo_level), 32'(lvl));
    for (int t = 0; t < 60 && burst_cnt - base != 6; t++) @(negedge clk);
    chk("drain_next_burst", 32'(burst_cnt - base), 32'd6);
    chk("drain_restart_addr", 32'(last_addr), 32'(BASE));
    chk("drain_flush_level", 32'(fifo_level), 32'd0);
    chk("drain_underflow_clr", 32'(underflow), 32'd0);
    for (int t = 0; t < 40 && fifo_level != 7'd16; t++) @(negedge clk);
    lcd_request = 1'b1;
    @(negedge clk);
    chk("restart_pixel0", 32'(lcd_data), 32'd0);
    @(negedge clk);
    chk("restart_pixel1", 32'(lcd_data), 32'd1);
    lcd_request = 1'b0;

    // Asynchronous reset in the middle of a burst.
    for (int t = 0; t < 100 && !(burst_cnt - base == 7 && beat_idx == 3); t++) @(negedge clk);
    chk("rst_mid_burst_reached", 32'(beat_idx), 32'd3);
    rst = 1'b1;
    #1;
    chk("arst_lcd_data", 32'(lcd_data), 32'd0);
    chk("arst_rd_req", 32'(rd_req), 32'd0);
    chk("arst_rd_addr", 32'(rd_addr), 32'(BASE));
    chk("arst_level", 32'(fifo_level), 32'd0);
    chk("arst_underflow", 32'(underflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (rd_req) seen = 1'b1;
    end
    chk("post_rst_no_req", 32'(seen), 32'd0);
    chk("post_rst_beats_ignored", 32'(fifo_level), 32'd0);

    // Whole frame with the consumer running.
    base = burst_cnt; lcd_request = 1'b1;
    lcd_framesync = 1'b1;
    @(negedge clk);
    lcd_framesync = 1'b0;
    for (int t = 0; t < 1000 && !(burst_cnt - base == NBURST && beat_idx == 16 && !rd_valid); t++)
      @(negedge clk);
    seen = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (rd_req) seen = 1'b1;
    end
    lcd_request = 1'b0;
    chk("frame_bursts", 32'(burst_cnt - base), 32'(NBURST));
    chk("frame_last_addr", 32'(last_addr), 32'(BASE + 22'd240));
    chk("frame_idle_no_req", 32'(seen), 32'd0);
    chk("frame_drained", 32'(fifo_level), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_frame_prefetch.md
Name: lcd_frame_prefetch

Overview:
- Upstream feeder for the LCD/VGA timing driver.
- Fetches one frame of 16-bit RGB565 pixels from the SDRAM read port in fixed-length bursts and buffers them in an internal FIFO.
- Answers the driver's per-pixel lcd_request with lcd_data on the following cycle.
- Restarts at the frame base address on every lcd_framesync.

Parameters:
- FIFO_DEPTH, 64: pixel FIFO depth in words; power of 2; must be >= 2*BURST_LEN.
- BURST_LEN, 16: words per SDRAM read burst; power of 2.
- H_PIXELS, 640: active pixels per line.
- V_LINES, 480: active lines per frame.
- ADDR_W, 22: SDRAM word-address width.
- FRAME_BASE, 0: word address of pixel (0,0).

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- rst, input, 1: asynchronous, active-high reset.
- lcd_request, input, 1: driver pops one pixel this cycle.
- lcd_framesync, input, 1: one-cycle pulse before the first active line of a frame.
- lcd_data, output, 16: pixel returned one cycle after lcd_request.
- rd_req, output, 1: burst read request; held until rd_ack.
- rd_addr, output, ADDR_W: burst start word address; stable while rd_req is high.
- rd_ack, input, 1: burst accepted, one-cycle pulse.
- rd_valid, input, 1: one returned data beat.
- rd_data, input, 16: beat data.
- fifo_level, output, log2(FIFO_DEPTH)+1: current FIFO occupancy.
- underflow, output, 1: sticky flag; lcd_request arrived while the FIFO was empty.

Behaviour:
- Reset values: lcd_data=0, rd_req=0, rd_addr=FRAME_BASE, fifo_level=0, underflow=0, state=IDLE, FIFO pointers and word counter cleared.
- TOTAL = H_PIXELS*V_LINES words per frame. fetched counter is 20 bits; rd_addr = FRAME_BASE + fetched, truncated to ADDR_W bits (wrap-around permitted).
- FSM states and transitions:
  - IDLE: wait for lcd_framesync -> FLUSH.
  - FLUSH: one cycle; clear FIFO pointers, set fetched=0, clear underflow -> REQ.
  - REQ: evaluated in order:
    - if fetched==TOTAL -> IDLE;
    - else if free space (FIFO_DEPTH-fifo_level) >= BURST_LEN, drive rd_req=1;
    - on rd_ack, drop rd_req the next cycle, beat_cnt=0 -> DATA.
  - DATA: each rd_valid writes rd_data to the FIFO and increments beat_cnt. On beat BURST_LEN: fetched += BURST_LEN -> REQ.
  - DRAIN: discard rd_valid beats until BURST_LEN beats of the outstanding burst have been counted -> FLUSH.
- Only one burst is ever outstanding. Space is reserved before the request, so the FIFO cannot overflow.
- lcd_framesync handling by state:
  - IDLE or REQ without an issued request: go straight to FLUSH, dropping rd_req.
  - REQ with rd_req pending and rd_ack in the same cycle: go to DRAIN.
  - DATA: go to DRAIN. A rd_valid in the same cycle counts toward the drain.
- Read path is registered. When lcd_request is high and the FIFO is non-empty, lcd_data <= head and the pointer advances. When empty, lcd_data <= 0 and underflow <= 1; the pointer does not move.
- A simultaneous FIFO write and read leaves fifo_level unchanged. A read in a FLUSH cycle returns 0 and does not set underflow.
- If the last burst would exceed TOTAL, it is still BURST_LEN long; TOTAL must be a multiple of BURST_LEN (640*480 = 307200 = 19200*16).
- Reset asserted mid-burst: all state returns to reset values immediately. Beats arriving afterwards in IDLE are ignored.

Test Plan:
- Reset, framesync, rd_ack 2 cycles after each rd_req, 16 beats per burst -> first rd_addr=0, then 16, 32, ...; fifo_level reaches 64 and rd_req stays low until level <= 48.
- FIFO prefilled with values 0x0000..0x003F, lcd_request held 64 cycles -> lcd_data shows 0x0000..0x003F, each one cycle after its request; underflow stays 0.
- lcd_request while fifo_level=0 -> lcd_data=0x0000 and underflow=1. underflow stays 1 until the next framesync, then clears.
- framesync after the 5th beat of the burst at address 0x40 -> remaining 11 beats are discarded; next rd_req has rd_addr=FRAME_BASE; fifo_level=0 after FLUSH.
- Full frame with FRAME_BASE=0x100000 -> exactly 19200 bursts; last rd_addr=0x100000+307184; FSM ends in IDLE with rd_req=0.
- rst pulsed during DATA -> all outputs at reset values on the next edge; no further rd_req until a framesync arrives.
